// File: rtl/psum_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : pe_arb_pkg
// Shared FSM state encoding and default sizing for the psum bus arbiter.
// Rev    : 1.0
// ============================================================================
package pe_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : psum_bus_arbiter_if
// PE-side request/beat bundle and buffer-side write port of the arbiter.
// Rev    : 1.0
// ============================================================================
interface psum_bus_arbiter_if
  import pe_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            wvalid;
  logic [NUM_REQ-1:0]            wlast;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic                          buf_full;
  logic [NUM_REQ-1:0]            gnt;
  logic                          buf_wen;
  logic [DATA_WIDTH-1:0]         buf_wdata;
  logic                          busy;

  modport master (
    output req, wvalid, wlast, wdata, buf_full,
    input  gnt, buf_wen, buf_wdata, busy
  );

  modport slave (
    input  req, wvalid, wlast, wdata, buf_full,
    output gnt, buf_wen, buf_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/psum_bus_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_priority_picker
// Round-robin pick: first requester searching upward from last_owner+1.
// Rev    : 1.0
// ============================================================================
module rr_priority_picker
  import pe_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  always_comb begin : p_pick
    int   cand;
    logic found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_owner) + i) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found              = 1'b1;
        pick[IDX_W'(cand)] = 1'b1;
        pick_idx           = IDX_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/psum_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : psum_bus_arbiter
// Round-robin owner of the global psum write buffer; optional burst cap
// selected by macro ARB_BURST_LIMIT_EN.
// Rev    : 1.0
// ============================================================================
module psum_bus_arbiter
  import pe_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  psum_bus_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("MAX_BURST must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               in_xfer;
  logic               accept;
  logic               limit_hit;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (bus.req),
    .last_owner(last_owner_q),
    .pick      (pick_oh),
    .pick_idx  (pick_idx)
  );

  // Every output is derived from the current state so reset clears them at once.
  assign in_xfer       = (state_q == XFER);
  assign accept        = in_xfer & bus.wvalid[sel_q] & ~bus.buf_full;
  assign bus.gnt       = in_xfer ? gnt_oh_q : '0;
  assign bus.busy      = in_xfer;
  assign bus.buf_wen   = accept;
  assign bus.buf_wdata = in_xfer ? bus.wdata[sel_q*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (!in_xfer) begin
      beat_cnt_d = '0;
    end else if (accept && (beat_cnt_q != CNT_W'(MAX_BURST))) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign limit_hit = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    gnt_oh_d     = gnt_oh_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d    = pick_idx;
          gnt_oh_d = pick_oh;
          state_d  = XFER;
        end
      end
      XFER: begin
        // A final beat stalled by buf_full keeps the grant until it lands.
        if (!bus.req[sel_q]) begin
          state_d = RELEASE;
        end else if (accept && (bus.wlast[sel_q] || limit_hit)) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        last_owner_d = sel_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      gnt_oh_q     <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gnt_oh_q     <= gnt_oh_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule
`default_nettype wire
